mux: RTL and testbench
======================

# mux

Four-input, select-driven multiplexer with a registered output, used wherever one of four equal-width data sources must be steered onto a single datapath lane. Select lines s1 (MSB) and s2 (LSB) choose among inputs a, b, c and d. By default the chosen value is captured on the rising clock edge, so downstream logic sees a glitch-free, clock-aligned output. A parameter allows a purely combinational build for contexts that cannot afford the cycle of latency.

## Interface
Parameters:
- WIDTH, 1, bit width of each data input and of o.
- REG_OUT, 1, 1 = output registered (one-cycle latency); 0 = combinational output, clk/rst_n unused.

Ports:
- clk  input  1  rising-edge clock; the single clock of the block.
- rst_n  input  1  asynchronous, active-low reset.
- a  input  WIDTH  data source 0.
- b  input  WIDTH  data source 1.
- c  input  WIDTH  data source 2.
- d  input  WIDTH  data source 3.
- s1  input  1  select MSB.
- s2  input  1  select LSB.
- o  output  WIDTH  selected data.

## Operation
- Select code sel = {s1, s2}:
  - 00 -> a
  - 01 -> b
  - 10 -> c
  - 11 -> d
- The selection decode is full-case. No combination of s1/s2 produces an unselected or latched value.
- X/Z on a select line: the combinational result is unspecified in simulation; synthesis must not infer latches.
- Non-selected inputs have no effect on o, whatever their values.
- Width rule: every bit of o comes from the same-index bit of the selected source. There is no extension, truncation or arithmetic.
- REG_OUT = 1:
  - o is a flop bank loaded every rising clk edge with the decoded value.
  - There is no enable; the bank loads every cycle.
- REG_OUT = 0:
  - o is driven continuously by the decode.
  - clk and rst_n are ignored.

## Timing
- Reset, REG_OUT = 1:
  - rst_n low forces o to all-zeros immediately, without waiting for a clock edge.
  - o stays zero while rst_n is low, regardless of clocks or inputs.
- Reset release: the first rising clk edge with rst_n high loads the selected value.
  - o therefore shows the first valid data one edge after release.
- Latency, REG_OUT = 1: o(n+1) = sel_value(n), where n is the clock edge sampling a..d, s1, s2. Exactly one cycle.
- Latency, REG_OUT = 0: zero cycles; o follows inputs after combinational delay only.
- Simultaneous change of select and data before an edge: the value registered is the decode of the values present at that edge.
- Reset asserted mid-stream: o clears asynchronously. The previously registered value is lost and not restored after release.
- Select toggling between edges has no effect on o (REG_OUT = 1). Only the values at the edge matter.

## Test plan
- Reset: drive rst_n = 0 with a=b=c=d=1, sel=11 -> o = 0 at once, and o holds 0 across several clock edges.
- Select sweep: WIDTH=1, a=1, b=0, c=0, d=0, step sel 00 -> 01 -> 10 -> 11, one step per cycle -> o = 1, 0, 0, 0, each one edge after the sel change.
  - Repeat with the single 1 on b, then on c, then on d -> the 1 appears only when sel = 01, 10, 11 respectively.
- Exhaustive: apply all 64 combinations of a, b, c, d, s1, s2 -> o matches the mapping table every time.
  - Spot checks: a=0, b=1, c=1, d=1, sel=10 -> o = 1; a=1, b=0, c=0, d=1, sel=00 -> o = 1.
- Latency and glitch: hold a=1, b=0, sel=00; toggle s2 high then low between two edges -> o stays 1.
  - Then set sel=01 before an edge -> o = 0 exactly one edge later.
- Mid-stream reset: with o = 1, pulse rst_n low between edges -> o = 0 immediately.
  - After release -> o reloads the selected value on the next edge.
- Combinational build: REG_OUT=0, WIDTH=8, a=0x11, b=0x22, c=0x33, d=0x44, sweep sel -> o = 0x11, 0x22, 0x33, 0x44 with no clock applied.

Source files
------------

// File: rtl/mux.sv
// ---------------------------------------------------------------------------
// mux
//
// Four-input, select-driven multiplexer that steers one of four equal-width
// data sources onto a single output lane. By default the output is registered,
// which gives downstream logic a glitch-free, clock-aligned value. Setting
// REG_OUT to 0 builds a purely combinational mux with no latency.
//
// Parameters:
//   WIDTH    bit width of each data input and of o
//   REG_OUT  1 = registered output (one-cycle latency)
//            0 = combinational output (clk and rst_n are ignored)
//
// Ports:
//   clk    in   1      rising-edge clock
//   rst_n  in   1      asynchronous, active-low reset (clears o)
//   a      in   WIDTH  data source 0 (sel = 00)
//   b      in   WIDTH  data source 1 (sel = 01)
//   c      in   WIDTH  data source 2 (sel = 10)
//   d      in   WIDTH  data source 3 (sel = 11)
//   s1     in   1      select MSB
//   s2     in   1      select LSB
//   o      out  WIDTH  selected data
// ---------------------------------------------------------------------------
module mux #(
    parameter int WIDTH   = 1,
    parameter bit REG_OUT = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    input  logic [WIDTH-1:0] d,
    input  logic             s1,
    input  logic             s2,
    output logic [WIDTH-1:0] o
);

    logic [1:0]       sel;
    logic [WIDTH-1:0] sel_value;

    assign sel = {s1, sel_lsb()};

    // Keep the select concatenation readable: s1 is the MSB, s2 the LSB.
    function automatic logic sel_lsb();
        return s2;
    endfunction

    // Full-case decode with a default arm, so no select value (including
    // X/Z in simulation) can leave sel_value unassigned and infer a latch.
    always_comb begin
        sel_value = a;
        case (sel)
            2'b00:   sel_value = a;
            2'b01:   sel_value = b;
            2'b10:   sel_value = c;
            2'b11:   sel_value = d;
            default: sel_value = a;
        endcase
    end

    generate
        if (REG_OUT) begin : g_reg
            // Flop bank loads every cycle; there is deliberately no enable.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    o <= '0;
                end else begin
                    o <= sel_value;
                end
            end
        end else begin : g_comb
            // Clock and reset have no function in this build; fold them into
            // a sink so they are visibly accounted for.
            logic unused_clk_rst;
            assign unused_clk_rst = clk ^ rst_n;
            assign o = sel_value;
        end
    endgenerate

endmodule

// File: tb/tb_mux.sv
// ---------------------------------------------------------------------------
// tb_mux
//
// Directed testbench for mux. Two instances are exercised:
//   u_reg   WIDTH=1, REG_OUT=1  registered build, clocked
//   u_comb  WIDTH=8, REG_OUT=0  combinational build, clock held low
// Expected values are hand-computed constants or derived from the select
// mapping table (00->a, 01->b, 10->c, 11->d).
// ---------------------------------------------------------------------------
module tb_mux;

    // Registered instance signals
    logic clk;
    logic rst_n;
    logic ra, rb, rc, rd;
    logic rs1, rs2;
    logic ro;

    // Combinational instance signals
    logic       comb_clk;
    logic       comb_rst_n;
    logic [7:0] ca, cb, cc, cd;
    logic       cs1, cs2;
    logic [7:0] co;

    int total;
    int bad;

    mux #(.WIDTH(1), .REG_OUT(1'b1)) u_reg (
        .clk   (clk),
        .rst_n (rst_n),
        .a     (ra),
        .b     (rb),
        .c     (rc),
        .d     (rd),
        .s1    (rs1),
        .s2    (rs2),
        .o     (ro)
    );

    mux #(.WIDTH(8), .REG_OUT(1'b0)) u_comb (
        .clk   (comb_clk),
        .rst_n (comb_rst_n),
        .a     (ca),
        .b     (cb),
        .c     (cc),
        .d     (cd),
        .s1    (cs1),
        .s2    (cs2),
        .o     (co)
    );

    // 10-time-unit clock, rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog so the run always ends on its own.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Single comparison point: counts every check, reports mismatches.
    task automatic checkOutput(input string tag, input logic [7:0] got,
                               input logic [7:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: actual=0x%02h required=0x%02h", tag, got, exp);
        end
    endtask

    // Drive the registered instance on the falling edge, well away from
    // the rising edge that samples the inputs.
    task automatic applyStimulus(input logic a_v, input logic b_v,
                                 input logic c_v, input logic d_v,
                                 input logic [1:0] sel_v);
        @(negedge clk);
        ra  = a_v;
        rb  = b_v;
        rc  = c_v;
        rd  = d_v;
        rs1 = sel_v[1];
        rs2 = sel_v[0];
    endtask

    // Wait for the loading edge, then sample just after it.
    task automatic stepEdge();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [3:0] srcs;
        logic [5:0] v;

        total = 0;
        bad   = 0;

        comb_clk   = 1'b0;
        comb_rst_n = 1'b0;
        ca = 8'h00; cb = 8'h00; cc = 8'h00; cd = 8'h00;
        cs1 = 1'b0; cs2 = 1'b0;

        // Reset with every input high and sel=11: o must be 0 at once.
        rst_n = 1'b0;
        ra = 1'b1; rb = 1'b1; rc = 1'b1; rd = 1'b1;
        rs1 = 1'b1; rs2 = 1'b1;
        #1;
        checkOutput("reset_immediate", {7'd0, ro}, 8'h00);
        for (int i = 0; i < 3; i++) begin
            stepEdge();
            checkOutput("reset_hold", {7'd0, ro}, 8'h00);
        end

        // Release reset; first edge after release loads the selected value.
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 2'b00);
        rst_n = 1'b1;
        #1;
        checkOutput("release_before_edge", {7'd0, ro}, 8'h00);
        stepEdge();
        checkOutput("release_first_load", {7'd0, ro}, 8'h01);

        // Select sweep: a single 1 on source p, o is 1 only when sel == p.
        for (int p = 0; p < 4; p++) begin
            for (int s = 0; s < 4; s++) begin
                applyStimulus(p == 0, p == 1, p == 2, p == 3, s[1:0]);
                stepEdge();
                checkOutput($sformatf("sweep_p%0d_s%0d", p, s), {7'd0, ro},
                            (p == s) ? 8'h01 : 8'h00);
            end
        end

        // Exhaustive: all 64 combinations of a, b, c, d, s1, s2.
        for (int i = 0; i < 64; i++) begin
            v    = i[5:0];
            srcs = v[3:0];
            applyStimulus(v[0], v[1], v[2], v[3], v[5:4]);
            stepEdge();
            checkOutput($sformatf("exh_%0d", i), {7'd0, ro},
                        {7'd0, srcs[v[5:4]]});
        end

        // Spot checks.
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 2'b10);
        stepEdge();
        checkOutput("spot_sel10", {7'd0, ro}, 8'h01);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 2'b00);
        stepEdge();
        checkOutput("spot_sel00", {7'd0, ro}, 8'h01);

        // Glitch: toggling s2 between edges must not disturb o.
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 2'b00);
        stepEdge();
        checkOutput("glitch_setup", {7'd0, ro}, 8'h01);
        #1;
        rs2 = 1'b1;
        #2;
        checkOutput("glitch_mid_toggle", {7'd0, ro}, 8'h01);
        rs2 = 1'b0;
        stepEdge();
        checkOutput("glitch_after_edge", {7'd0, ro}, 8'h01);

        // Latency: switch to sel=01 before an edge; o changes exactly one edge later.
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 2'b01);
        #1;
        checkOutput("latency_before_edge", {7'd0, ro}, 8'h01);
        stepEdge();
        checkOutput("latency_one_edge", {7'd0, ro}, 8'h00);

        // Mid-stream reset: clear immediately, no restore, reload on next edge.
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 2'b00);
        stepEdge();
        checkOutput("midreset_setup", {7'd0, ro}, 8'h01);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("midreset_immediate", {7'd0, ro}, 8'h00);
        #1;
        rst_n = 1'b1;
        #1;
        checkOutput("midreset_no_restore", {7'd0, ro}, 8'h00);
        stepEdge();
        checkOutput("midreset_reload", {7'd0, ro}, 8'h01);

        // Combinational build: no clock, reset held low, o follows sel.
        ca = 8'h11; cb = 8'h22; cc = 8'h33; cd = 8'h44;
        cs1 = 1'b0; cs2 = 1'b0;
        #1;
        checkOutput("comb_sel00", co, 8'h11);
        cs1 = 1'b0; cs2 = 1'b1;
        #1;
        checkOutput("comb_sel01", co, 8'h22);
        cs1 = 1'b1; cs2 = 1'b0;
        #1;
        checkOutput("comb_sel10", co, 8'h33);
        cs1 = 1'b1; cs2 = 1'b1;
        #1;
        checkOutput("comb_sel11", co, 8'h44);

        // Non-selected inputs have no effect; full-width bit mapping.
        ca = 8'hFF; cb = 8'h00; cc = 8'h5A;
        cd = 8'hA5;
        #1;
        checkOutput("comb_unselected", co, 8'hA5);
        cs1 = 1'b1; cs2 = 1'b0;
        #1;
        checkOutput("comb_bitmap", co, 8'h5A);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
